// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- eight-way round-robin arbiter with grant locking and a hold
// timeout. It produces the select for a downstream 8-to-1 mux, and that select
// stays constant for the whole of a granted transaction.
//
// Ports:
//   i_Clock     rising-edge clock
//   i_Reset     asynchronous, active-high reset
//   i_Request   [7:0] request vector; bit n = requester n wants the path
//   i_Release   current owner is finished; only looked at while o_Valid=1
//   o_Grant     [7:0] one-hot grant, zero when idle
//   o_Select    [2:0] index of the granted requester (mux select)
//   o_Valid     a grant is active
//   o_Timeout   one-cycle pulse after a forced release
//   o_DbgState  FSM state (0=IDLE, 1=BUSY), for checkers
//   o_DbgPtr    [2:0] round-robin priority pointer, for checkers
//
// Handshake: a requester holds its i_Request bit until it sees its o_Grant
// bit. After that the grant belongs to it until the edge where i_Release=1 is
// sampled, or until the hold timeout forces it off. Dropping i_Request during
// the grant does not end it. i_Release has no effect while o_Valid=0.
module rr_arbiter8 #(
  parameter int MAX_HOLD  = 16,  // 0 disables the timeout
  parameter int CNT_WIDTH = 16   // MAX_HOLD must fit in CNT_WIDTH bits
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic [7:0] i_Request,
  input  logic       i_Release,
  output logic [7:0] o_Grant,
  output logic [2:0] o_Select,
  output logic       o_Valid,
  output logic       o_Timeout,
  output logic       o_DbgState,
  output logic [2:0] o_DbgPtr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LIM = CNT_WIDTH'(MAX_HOLD);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   TMO_EN   = (MAX_HOLD != 0);

  state_t               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [2:0]           sel_q, sel_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tout_q, tout_d;

  // Arbitration. In BUSY the scan starts at owner+1, which is the pointer
  // value that a release or timeout at this edge installs. The handover
  // therefore arbitrates against the new priority order in the same cycle,
  // and no idle cycle is inserted.
  logic [2:0]  scan_ptr;
  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic [2:0]  win_idx;
  logic        win_any;

  always_comb begin
    scan_ptr = (state_q == BUSY) ? sel_q + 3'd1 : ptr_q;
    // Rotate right so that bit k of req_rot is requester (scan_ptr + k) mod 8.
    req_dbl  = {i_Request, i_Request} >> scan_ptr;
    req_rot  = req_dbl[7:0];
    win_off  = 3'd0;
    // Descending loop: the lowest set offset is written last and wins.
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) win_off = 3'(i);
    end
    win_idx  = scan_ptr + win_off;
    win_any  = |i_Request;
  end

  // End-of-grant events. A release on the same edge as the hold limit takes
  // precedence and counts as a normal release.
  logic rel_ev;
  logic tmo_ev;

  always_comb begin
    rel_ev = (state_q == BUSY) && i_Release;
    tmo_ev = (state_q == BUSY) && TMO_EN && (cnt_q == HOLD_LIM) && !i_Release;
  end

  // State register
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = BUSY;
          sel_d   = win_idx;
          cnt_d   = CNT_ONE;
        end
      end
      BUSY: begin
        if (rel_ev || tmo_ev) begin
          tout_d = tmo_ev;
          ptr_d  = sel_q + 3'd1;
          if (win_any) begin
            sel_d = win_idx;
            cnt_d = CNT_ONE;
          end else begin
            // When the arbiter goes idle, sel_q keeps its last value, so the
            // mux select does not move.
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: decoded only from registers, so they change only on an edge or
  // on reset.
  always_comb begin
    o_Valid    = (state_q == BUSY);
    o_Grant    = (state_q == BUSY) ? (8'b1 << sel_q) : 8'b0;
    o_Select   = sel_q;
    o_Timeout  = tout_q;
    o_DbgState = state_q;
    o_DbgPtr   = ptr_q;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Eight-way round-robin arbiter with grant locking and hold timeout.
- Produces the 3-bit select that drives the downstream 8-to-1 data mux, plus one-hot grant and valid.
- Sits directly upstream of the mux on shared writeback/bus paths.
- Guarantees the select is stable for the whole of a granted transaction.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before it is force-released. 0 disables the timeout.
- CNT_WIDTH, 16, width of the internal hold counter. MAX_HOLD must be at most 2^CNT_WIDTH-1.

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Request  input  8  request vector; bit n means requester n wants the path.
- i_Release  input  1  current owner finished; sampled only while o_Valid=1.
- o_Grant  output  8  one-hot grant; all zero when idle.
- o_Select  output  3  index of the granted requester; connects to the mux i_Select.
- o_Valid  output  1  a grant is active.
- o_Timeout  output  1  one-cycle pulse after a forced release.

Behaviour:
- Reset (async, active-high): o_Grant=0, o_Select=0, o_Valid=0, o_Timeout=0, state=IDLE, priority pointer=0, hold counter=0. Reset may assert mid-grant; the grant drops immediately and the pointer returns to 0.
- Arbitration function: starting at the pointer p, scan indices p, p+1, ..., p+7 (mod 8). The first index with i_Request set wins.
- State IDLE:
  - If any i_Request bit is set at a rising edge, register the winner at that edge: o_Select=idx, o_Grant=1<<idx, o_Valid=1, counter=1, state=BUSY.
  - Latency is 1 cycle from request to grant.
  - i_Release is ignored in IDLE.
- State BUSY:
  - o_Grant, o_Select and o_Valid hold constant.
  - The owner dropping its i_Request does not end the grant; only release or timeout ends it.
  - The counter increments each cycle, saturating at its maximum.
- Release event: i_Release=1 at an edge while BUSY. Timeout event: MAX_HOLD!=0, counter==MAX_HOLD and i_Release=0.
- On either event at an edge:
  - Pointer becomes (idx+1) mod 8.
  - Arbitrate immediately using the new pointer and the current i_Request. This gives zero-bubble handover.
  - The previous owner may win again only if no other bit is set.
  - If a winner exists, load the new grant and set counter=1. Otherwise: state=IDLE, o_Grant=0, o_Valid=0, and o_Select keeps its last value.
- o_Timeout is 1 for exactly the cycle after a timeout event, and 0 otherwise.
- If release and timeout fall on the same edge, it is treated as a release: no o_Timeout pulse.
- A grant lasts at most MAX_HOLD cycles when MAX_HOLD is non-zero.
- Invariants:
  - o_Grant is zero or one-hot.
  - When o_Valid=1, o_Grant == 1<<o_Select.
  - No output changes except on an edge or on reset.

Test Plan:
- Reset, then i_Request=8'b0000_0100 -> one cycle later o_Select=2, o_Grant=8'h04, o_Valid=1. i_Release at the next edge -> o_Valid=0, o_Select stays 2.
- i_Request=8'hFF held, i_Release pulsed every 3rd cycle -> the grant sequence is 0,1,2,...,7,0 with no idle cycle between grants.
- Pointer=5 (after granting 4), i_Request=8'b0001_0001 -> next grant is index 0 (scan 5,6,7,0). After release, the next grant is index 4.
- MAX_HOLD=4, requester 3 granted, never releases, i_Request=8'h08 only:
  - o_Valid is high for 4 cycles, then forced release.
  - o_Timeout=1 for one cycle.
  - Requester 3 is re-granted immediately (sole requester).
- Same setup, but i_Release=1 on the cycle where counter==4 -> normal release, o_Timeout stays 0.
- Assert i_Reset asynchronously mid-grant (o_Select=6) -> o_Grant, o_Valid and o_Select go to 0 without a clock edge. After deassert, i_Request=8'hC0 grants index 6 (pointer back at 0).
